// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the parametrised up/down modulo counter.
//   - dir_e       : direction encoding (UP=1, DOWN=0), matches the u_d pin.
//   - CLAMP_W     : fixed working width of the clamp helper. It covers
//                   WIDTH up to 32 plus one guard bit.
//   - MOD_EXTRA   : extra bits added to WIDTH for the modulus/arithmetic width.
//   - mod_width() : WIDTH+1. Wide enough to hold MAX+1 and count+s without loss.
//   - clamp()     : min(value, limit) on CLAMP_W-bit unsigned operands.
// Optional feature macro used by the counter files: COUNTER_UPDN_SAT_EN.
package counter_pkg;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    localparam int CLAMP_W   = 33;
    localparam int MOD_EXTRA = 1;

    function automatic int mod_width(input int width);
        return width + MOD_EXTRA;
    endfunction

    function automatic logic [CLAMP_W-1:0] clamp(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/counter_updown_next.sv
// counter_updown_next
// Purely combinational next-value calculator for the modulo up/down counter.
// It computes the candidate value for an enabled edge and flags a boundary
// event (wrap, or clamp in saturating mode).
// Ports:
//   count    in  WIDTH  current registered value (always within 0..MAX)
//   s        in  WIDTH  effective step, already limited to MAX
//   u_d      in  1      1 = up, 0 = down
//   sat      in  1      saturate instead of wrap (only with COUNTER_UPDN_SAT_EN)
//   next     out WIDTH  value to register on an enabled edge
//   boundary out 1      wrap/clamp happened on this step
// Optional feature macro: COUNTER_UPDN_SAT_EN.
module counter_updown_next
    import counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             u_d,
`ifdef COUNTER_UPDN_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] next,
    output logic             boundary
);

    localparam int           MW    = mod_width(WIDTH);
    localparam logic [MW-1:0] MAX_V = MW'(MAX);
    localparam logic [MW-1:0] MOD_V = MAX_V + MW'(1);

    logic [MW-1:0] count_x;
    logic [MW-1:0] s_x;
    logic [MW-1:0] sum;
    logic [MW-1:0] nx;

    always_comb begin
        count_x  = {1'b0, count};
        s_x      = {1'b0, s};
        sum      = count_x + s_x;
        nx       = count_x;
        boundary = 1'b0;

        if (dir_e'(u_d) == UP) begin
            if (sum <= MAX_V) begin
                nx = sum;
            end else begin
                // sum >= MOD here, so the subtraction cannot underflow
                boundary = 1'b1;
                nx       = sum - MOD_V;
`ifdef COUNTER_UPDN_SAT_EN
                if (sat) nx = MAX_V;
`endif
            end
        end else begin
            if (count_x >= s_x) begin
                nx = count_x - s_x;
            end else begin
                // count+MOD-s computed as MOD-(s-count) so that no
                // intermediate ever exceeds MW bits
                boundary = 1'b1;
                nx       = MOD_V - (s_x - count_x);
`ifdef COUNTER_UPDN_SAT_EN
                if (sat) nx = '0;
`endif
            end
        end

        next = WIDTH'(nx);
    end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
// Parametrised up/down modulo counter with synchronous load, clock enable,
// programmable step and a registered one-cycle boundary-event pulse.
// Ports:
//   clk     in  1       clock, rising edge
//   rst     in  1       synchronous reset, active high
//   en      in  1       count enable
//   load    in  1       synchronous load of data (clamped to MAX)
//   u_d     in  1       1 = count up, 0 = count down
//   data    in  WIDTH   load value
//   step    in  STEP_W  step magnitude (limited to MAX)
//   sat     in  1       saturate mode (only with COUNTER_UPDN_SAT_EN)
//   count   out WIDTH   registered count, range 0..MAX
//   evt     out 1       previous update wrapped or clamped
//   at_max  out 1       count == MAX (combinational)
//   at_zero out 1       count == 0   (combinational)
// Optional feature macro: COUNTER_UPDN_SAT_EN adds the sat port and the
// saturating behaviour. Without it the counter always wraps.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int              WIDTH  = 8,
    parameter longint unsigned MAX    = (64'd1 << WIDTH) - 64'd1,
    parameter int              STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              u_d,
    input  logic [WIDTH-1:0]  data,
    input  logic [STEP_W-1:0] step,
`ifdef COUNTER_UPDN_SAT_EN
    input  logic              sat,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              evt,
    output logic              at_max,
    output logic              at_zero
);

    localparam int            MW    = mod_width(WIDTH);
    localparam logic [MW-1:0] MAX_V = MW'(MAX);

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next;
    logic             boundary;

    // Step and load are limited, never wrapped, so count stays within 0..MAX
    assign s_eff    = WIDTH'(clamp(CLAMP_W'(step), CLAMP_W'(MAX_V)));
    assign load_val = WIDTH'(clamp(CLAMP_W'(data), CLAMP_W'(MAX_V)));

    counter_updown_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .count    (count),
        .s        (s_eff),
        .u_d      (u_d),
`ifdef COUNTER_UPDN_SAT_EN
        .sat      (sat),
`endif
        .next     (next),
        .boundary (boundary)
    );

    // Priority: reset, load, enable, hold. evt is cleared on every edge
    // that does not itself wrap or clamp, so it is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            evt   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            evt   <= 1'b0;
        end else if (en) begin
            count <= next;
            evt   <= boundary;
        end else begin
            evt   <= 1'b0;
        end
    end

    assign at_max  = ({1'b0, count} == MAX_V);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
module tb_counter_updown_mod;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic              u_d = 1'b1;
    logic [WIDTH-1:0]  data = '0;
    logic [STEP_W-1:0] step = '0;
`ifdef COUNTER_UPDN_SAT_EN
    logic              sat = 1'b0;
`endif
    logic [WIDTH-1:0]  count;
    logic              evt;
    logic              at_max;
    logic              at_zero;

    int tests  = 0;
    int failed = 0;

    counter_updown_mod #(
        .WIDTH  (WIDTH),
        .MAX    (64'd9),
        .STEP_W (STEP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .u_d     (u_d),
        .data    (data),
        .step    (step),
`ifdef COUNTER_UPDN_SAT_EN
        .sat     (sat),
`endif
        .count   (count),
        .evt     (evt),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks count, evt, at_max and at_zero together.
    task automatic check_all(input string tag, input int c, input bit e, input bit mx, input bit z);
        check({tag, ".count"},   32'(count),   32'(c));
        check({tag, ".evt"},     32'(evt),     32'(e));
        check({tag, ".at_max"},  32'(at_max),  32'(mx));
        check({tag, ".at_zero"}, 32'(at_zero), 32'(z));
    endtask

    initial begin
        // Reset held 2 cycles, load/en also asserted: reset wins
        #1;
        rst = 1'b1; load = 1'b1; data = 8'd5; en = 1'b1;
        tick(); tick();
        check_all("reset", 0, 0, 0, 1);

        // Load 7, then up by 3 -> decade wrap to 0 with evt
        rst = 1'b0; load = 1'b1; data = 8'd7; en = 1'b0;
        tick();
        check_all("load7", 7, 0, 0, 0);
        load = 1'b0; en = 1'b1; u_d = 1'b1; step = 4'd3;
        tick();
        check_all("up_wrap", 0, 1, 0, 1);
        tick();
        check_all("up_after_wrap", 3, 0, 0, 0);

        // Load 1, down by 4 -> wrap to 7 with evt, then hold 3 cycles
        load = 1'b1; data = 8'd1;
        tick();
        check_all("load1", 1, 0, 0, 0);
        load = 1'b0; u_d = 1'b0; step = 4'd4;
        tick();
        check_all("down_wrap", 7, 1, 0, 0);
        en = 1'b0;
        tick();
        check_all("hold1", 7, 0, 0, 0);
        tick(); tick();
        check_all("hold3", 7, 0, 0, 0);

        // Load above MAX clamps to 9; load beats en
        load = 1'b1; data = 8'd200; en = 1'b1; u_d = 1'b1; step = 4'd1;
        tick();
        check_all("load_clamp", 9, 0, 1, 0);
        // step 15 limited to 9: 9+9=18 -> 8 with evt
        load = 1'b0; step = 4'd15;
        tick();
        check_all("step_clamp", 8, 1, 0, 0);

        // Direction change on any cycle, no penalty
        u_d = 1'b0; step = 4'd2;
        tick();
        check_all("down2", 6, 0, 0, 0);
        u_d = 1'b1; step = 4'd3;
        tick();
        check_all("up3_to_max", 9, 0, 1, 0);
        // s = 0 leaves count unchanged without evt
        step = 4'd0;
        tick();
        check_all("step0", 9, 0, 1, 0);

        // Mid-count reset
        load = 1'b1; data = 8'd0;
        tick();
        load = 1'b0; step = 4'd1; u_d = 1'b1;
        tick();
        check_all("run1", 1, 0, 0, 0);
        tick();
        check_all("run2", 2, 0, 0, 0);
        rst = 1'b1;
        tick();
        check_all("mid_reset", 0, 0, 0, 1);
        rst = 1'b0;
        tick();
        check_all("resume", 1, 0, 0, 0);

        // Down to exactly 0 is not a wrap; one more step wraps to 9
        u_d = 1'b0;
        tick();
        check_all("down_exact0", 0, 0, 0, 1);
        tick();
        check_all("down_wrap_max", 9, 1, 1, 0);

`ifdef COUNTER_UPDN_SAT_EN
        // Saturating mode
        load = 1'b1; data = 8'd8;
        tick();
        load = 1'b0; sat = 1'b1; u_d = 1'b1; step = 4'd5;
        tick();
        check_all("sat_up", 9, 1, 1, 0);
        tick();
        check_all("sat_up_again", 9, 1, 1, 0);
        u_d = 1'b0; step = 4'd12;
        tick();
        check_all("sat_down_exact", 0, 0, 0, 1);
        step = 4'd1;
        tick();
        check_all("sat_down_clamp", 0, 1, 0, 1);
        sat = 1'b0;
        tick();
        check_all("nosat_wrap", 9, 1, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down counter with synchronous load, clock enable, programmable step and modulo wrap-around, plus a registered boundary-event pulse. It is the general-purpose successor to the team's fixed 8-bit up/down counter with load, for timers, address generators and decade/modulo counting. When `COUNTER_UPDN_SAT_EN` is defined, an optional saturating mode is compiled in.

## Interface
- `WIDTH`, 8: counter width in bits; legal range is 2–32.
- `MAX`, 2**WIDTH-1: terminal value. Count range is 0..MAX, and the modulus is MAX+1. Legal range is 1..2**WIDTH-1.
- `STEP_W`, 4: width of the step input. Must satisfy STEP_W ≤ WIDTH.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  count enable. When low, `count` holds.
- `load`  in  1  synchronous load of `data`.
- `u_d`  in  1  direction: 1 counts up, 0 counts down.
- `data`  in  WIDTH  load value.
- `step`  in  STEP_W  increment/decrement magnitude.
- `sat`  in  1  saturate mode select. Present only with `COUNTER_UPDN_SAT_EN`.
- `count`  out  WIDTH  registered counter value.
- `evt`  out  1  registered one-cycle pulse: the previous update crossed or hit a boundary.
- `at_max`  out  1  combinational, `count == MAX`.
- `at_zero`  out  1  combinational, `count == 0`.

## Operation
- Update priority per edge, highest first: `rst`, then `load`, then `en`, else hold.
- `rst`=1 sets `count`=0 and `evt`=0. Therefore `at_zero`=1, and `at_max`=1 only when MAX=0, which is illegal.
- `load`=1 loads `count` ← min(`data`, MAX). Data above MAX is clamped, never wrapped. Sets `evt`=0. Ignores `en` and `u_d`.
- Effective step s = min(`step`, MAX), zero-extended. Arithmetic is carried in WIDTH+1 bits so no intermediate overflow is lost.
- Up count, `en`=1, `u_d`=1:
  - If `count`+s ≤ MAX, then `count` ← `count`+s.
  - Otherwise wrap: `count` ← `count`+s−(MAX+1), and `evt`=1.
- Down count, `en`=1, `u_d`=0:
  - If `count` ≥ s, then `count` ← `count`−s.
  - Otherwise wrap: `count` ← `count`+(MAX+1)−s, and `evt`=1.
- s=0 with `en`=1 leaves `count` unchanged and sets `evt`=0.
- `evt` is 0 on every edge where no wrap or clamp occurred, including hold edges. It is never asserted for two cycles from a single event.
- `u_d` may change on any cycle. It takes effect on the same edge with no turnaround penalty.

## Timing
- Latency is 1 cycle from input sampling to `count`/`evt`.
- `at_max`/`at_zero` follow `count` combinationally, in the same cycle.
- Reset mid-count takes effect at the next edge and discards any simultaneous load or count.
- No multicycle or handshake paths. Single-cycle next-state logic.

## Configuration
- `COUNTER_UPDN_SAT_EN` defined: the `sat` port exists.
  - With `sat`=1, an up overflow clamps `count` to MAX and a down underflow clamps it to 0. `evt`=1 on the clamping edge.
  - When already at MAX, further up steps hold MAX and pulse `evt` each enabled edge. The same applies at 0 counting down.
  - With `sat`=0, behaviour is identical to wrap mode.
- `COUNTER_UPDN_SAT_EN` not defined: no `sat` port, wrap mode only, and no saturation logic is synthesised.

## Structure
- Shared package `counter_pkg`:
  - clamp helper (min of value and limit);
  - localparam for the modulus width (WIDTH+1);
  - direction encodings UP=1, DOWN=0.
- Sub-module `counter_updown_next`, purely combinational. Inputs: `count`, s, `u_d`, `sat`. Outputs: next value and boundary flag. The top holds only registers and priority muxing.

## Test plan
- Reset: WIDTH=8, MAX=9. Hold `rst`=1 for 2 cycles with `load`=1 and `data`=5 → `count`=0, `evt`=0, `at_zero`=1.
- Decade wrap: `count`=7, `step`=3, up → `count`=0 and `evt`=1 for exactly one cycle. Next step up → `count`=3, `evt`=0.
- Down wrap: `count`=1, `step`=4, down → `count`=7, `evt`=1. With `en`=0 for 3 cycles → `count` stays 7, `evt`=0.
- Load clamp and priority: `data`=200, `load`=1, `en`=1 → `count`=9, `at_max`=1, `evt`=0. Then `step`=15 up → s=9 → `count`=8, `evt`=1.
- Saturation (macro on, `sat`=1): `count`=8, `step`=5, up → `count`=9, `evt`=1. Up again → 9, `evt`=1. Then `step`=12 down → s=9 → `count`=0, `evt`=0, since 9−9=0 hits 0 exactly without underflow.
- Mid-operation reset: while counting up every cycle, assert `rst` for 1 cycle → the next edge gives `count`=0, and counting resumes from 0 the edge after.
